elastic_pipe_reg: RTL
=====================

ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning payload width (e.g. ALU result plus store data).
REQ-002 The block SHALL have parameter CTRL_W, default 4, meaning control-bit width (mem_write, mem_read, wbsel, reg_write_en).
REQ-003 The block SHALL have parameter ADDR_W, default 5, meaning destination register address width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1) forming the upstream handshake.
REQ-007 The block SHALL have ports in_data (input, DATA_W), in_ctrl (input, CTRL_W) and in_addr (input, ADDR_W) as the upstream payload.
REQ-008 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1) forming the downstream handshake.
REQ-009 The block SHALL have ports out_data (output, DATA_W), out_ctrl (output, CTRL_W) and out_addr (output, ADDR_W) as the downstream payload.
REQ-010 The block SHALL have port busywait, input, 1, memory stall; when high it blocks the downstream transfer.
REQ-011 The block SHALL have port flush, input, 1, which discards all held entries.
REQ-012 The block SHALL have port occupancy, output, 2, giving the number of held entries (0..2).

Function
REQ-013 Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready & !busywait.
REQ-014 Storage SHALL be two entries: main slot (drives the outputs) and skid slot; states are EMPTY, ONE and FULL.
REQ-015 in_ready SHALL be high iff the state is not FULL and reset is low, decoded from registered state only, with no combinational path from out_ready.
REQ-016 EMPTY: in_fire loads main and moves to ONE.
REQ-017 ONE: in_fire together with out_fire replaces main and stays in ONE; in_fire alone loads skid and moves to FULL; out_fire alone moves to EMPTY.
REQ-018 FULL: out_fire copies skid to main and moves to ONE; in_fire is impossible in this state.
REQ-019 Latency SHALL be 1 cycle: data accepted at edge N is visible at out_* after edge N; sustained throughput SHALL be 1 per cycle with out_ready high and busywait low.
REQ-020 out_valid SHALL be high iff the state is not EMPTY.
REQ-021 When out_valid is low, out_ctrl SHALL read all-zero (bubble), so no memory or register write is issued from a bubble.
REQ-022 While out_valid is high and out_fire is low, out_data, out_ctrl and out_addr SHALL stay stable.
REQ-023 flush SHALL move the state to EMPTY at the next edge and drop any same-cycle in_fire.
REQ-024 Priority SHALL be reset > flush > normal handshake.
REQ-025 occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE and FULL respectively.
REQ-026 Entries SHALL leave in strict FIFO order; no entry may be duplicated or lost except by flush or reset.

Reset
REQ-027 With reset high at an edge, the state SHALL become EMPTY and all payload registers SHALL become 0.
REQ-028 During reset, out_valid = 0, out_ctrl = 0, occupancy = 0 and in_ready = 0; in_ready SHALL rise in the first cycle after reset deasserts.
REQ-029 Reset asserted mid-transfer SHALL discard both slots without emitting a partial output.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the state enum (EMPTY/ONE/FULL), the occupancy width constant (2) and the default widths.
REQ-031 The block SHALL use one sub-module, pipe_slot, a load-enabled DATA_W+CTRL_W+ADDR_W register with synchronous clear, instantiated twice.

Verification
REQ-032 Scenario: reset for 2 cycles, then idle -> out_valid = 0, out_ctrl = 0, occupancy = 0, in_ready = 1 from the first post-reset cycle.
REQ-033 Scenario: stream data 1..8 with out_ready = 1 and busywait = 0 -> out_data 1..8 in order, one per cycle, 1-cycle lag.
REQ-034 Scenario: stream with busywait = 1 for 3 cycles -> occupancy reaches 2, in_ready = 0, outputs held stable, no data lost after release.
REQ-035 Scenario: FULL state with flush = 1 and in_valid = 1 in the same cycle -> next cycle occupancy = 0, out_ctrl = 0, the flushed-cycle input never appears.
REQ-036 Scenario: reset asserted while FULL with out_ready = 1 -> no output fire, all outputs zero next cycle.
REQ-037 Scenario: random in_valid, out_ready and busywait for 10k cycles -> scoreboard order and data exact, out_ctrl = 0 whenever out_valid = 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam int OCC_W          = 2;
  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_CTRL_W = 4;
  localparam int DEFAULT_ADDR_W = 5;

endpackage

// File: rtl/pipe_slot.sv
// Load-enabled payload register with synchronous clear (clear wins over load).
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Two-entry elastic pipeline register (main + skid slot) with flush and memory stall.
module elastic_pipe_reg #(
  parameter int DATA_W = pipe_pkg::DEFAULT_DATA_W,
  parameter int CTRL_W = pipe_pkg::DEFAULT_CTRL_W,
  parameter int ADDR_W = pipe_pkg::DEFAULT_ADDR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [ADDR_W-1:0]          in_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [ADDR_W-1:0]          out_addr,
  input  logic                       busywait,
  input  logic                       flush,
  output logic [pipe_pkg::OCC_W-1:0] occupancy,
  output pipe_pkg::pipe_state_e      state_dbg
);
  import pipe_pkg::*;

  localparam int PW = DATA_W + CTRL_W + ADDR_W;

  pipe_state_e   state_q, state_d;
  logic [PW-1:0] in_word, main_d, main_q, skid_q;
  logic          main_load, skid_load, main_from_skid, slot_clr;
  logic          in_fire, out_fire;

  // Handshake: a beat transfers on an edge where valid and ready are both high
  // (downstream additionally needs busywait low). valid never waits on ready,
  // in_ready depends only on registered state and reset, and the payload holds
  // steady while out_valid is high and no transfer occurs.
  assign in_ready  = (state_q != FULL) && !reset;
  assign out_valid = (state_q != EMPTY) && !reset;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready && !busywait;

  assign occupancy = reset ? '0 : OCC_W'(state_q);
  assign state_dbg = state_q;

  assign in_word  = {in_data, in_ctrl, in_addr};
  assign main_d   = main_from_skid ? skid_q : in_word;
  assign slot_clr = reset || flush;

  // Bubbles present zero control so no write is issued downstream.
  assign out_data = main_q[PW-1 -: DATA_W];
  assign out_ctrl = out_valid ? main_q[ADDR_W +: CTRL_W] : '0;
  assign out_addr = main_q[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  pipe_slot #(.W(PW)) u_main (
    .clk  (clk),
    .clr  (slot_clr),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  pipe_slot #(.W(PW)) u_skid (
    .clk  (clk),
    .clr  (slot_clr),
    .load (skid_load),
    .d    (in_word),
    .q    (skid_q)
  );

endmodule
